pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. Drives the hold (stall) and bubble (flush) controls of the PC and of every inter-stage buffer, including the store-data buffer that carries rs2 read data from ID to EX. Also generates the ALU-operand and store-data forwarding selects, and freezes the whole pipe during multi-cycle data-memory accesses with a watchdog. Sits beside the datapath; it reads register indices and control bits from the ID, EX, MEM and WB stages.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  // Operand / store-data source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Controller state: normal sequencing, or whole-pipe hold on a slow data access
  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } ctrl_state_e;

  // A writing stage targets this source register; x0 never matches
  function automatic logic src_match(input logic wr,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] src);
    return wr && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath-side signal bundle of the hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_hazard_ctrl_pkg::*;

  // Stage information from the datapath
  logic [REG_IDX_W-1:0] rs1_id;
  logic [REG_IDX_W-1:0] rs2_id;
  logic                 rs1_used_id;
  logic                 rs2_used_id;
  logic [REG_IDX_W-1:0] rd_ex;
  logic [REG_IDX_W-1:0] rd_mem;
  logic [REG_IDX_W-1:0] rd_wb;
  logic                 wr_ex;
  logic                 wr_mem;
  logic                 wr_wb;
  logic                 load_ex;
  logic                 branch_taken_ex;
  logic                 dmem_req;
  logic                 dmem_ready;

  // Sequencing controls back to the datapath
  logic                 stall_pc;
  logic                 stall_ifid;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 freeze;
  fwd_sel_e             fwd_a;
  fwd_sel_e             fwd_b;
  fwd_sel_e             fwd_sd;
  logic                 mem_timeout;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  // Datapath side
  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    output rd_ex, rd_mem, rd_wb, wr_ex, wr_mem, wr_wb,
    output load_ex, branch_taken_ex, dmem_req, dmem_ready,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, freeze,
    input  fwd_a, fwd_b, fwd_sd, mem_timeout, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    input  rd_ex, rd_mem, rd_wb, wr_ex, wr_mem, wr_wb,
    input  load_ex, branch_taken_ex, dmem_req, dmem_ready,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, freeze,
    output fwd_a, fwd_b, fwd_sd, mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - forwarding comparator for one source operand
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 wr_mem,
  input  logic [REG_IDX_W-1:0] rd_mem,
  input  logic                 wr_wb,
  input  logic [REG_IDX_W-1:0] rd_wb,
  output fwd_sel_e             sel
);

  // The younger EX-MEM result wins over the older MEM-WB result
  always_comb begin
    sel = FWD_RF;
    if (src_match(wr_mem, rd_mem, src)) begin
      sel = FWD_MEM;
    end else if (src_match(wr_wb, rd_wb, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze sequencing and forwarding for the 5-stage core
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  ctrl_state_e      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic     load_use;
  logic     freeze_raw;
  logic     timeout_raw;
  logic     stall_raw;
  logic     flush_if_raw;
  logic     flush_id_raw;
  fwd_sel_e fwd_a_raw;
  fwd_sel_e fwd_b_raw;
  fwd_sel_e fwd_sd_raw;

  // Hazard decode; priority is freeze, then branch flush, then load-use
  always_comb begin
    load_use     = (src_match(bus.load_ex & bus.wr_ex, bus.rd_ex, bus.rs1_id) & bus.rs1_used_id)
                 | (src_match(bus.load_ex & bus.wr_ex, bus.rd_ex, bus.rs2_id) & bus.rs2_used_id);
    // In FREEZE a ready response falls back to the RUN rules, where it cannot freeze
    freeze_raw   = !bus.dmem_ready && ((state == FREEZE) || bus.dmem_req);
    timeout_raw  = (state == FREEZE) && !bus.dmem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    stall_raw    = freeze_raw | (!bus.branch_taken_ex & load_use);
    flush_if_raw = !freeze_raw & bus.branch_taken_ex;
    flush_id_raw = !freeze_raw & (bus.branch_taken_ex | load_use);
  end

  fwd_unit u_fwd_a (
    .src    (bus.rs1_id),
    .wr_mem (bus.wr_mem),
    .rd_mem (bus.rd_mem),
    .wr_wb  (bus.wr_wb),
    .rd_wb  (bus.rd_wb),
    .sel    (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src    (bus.rs2_id),
    .wr_mem (bus.wr_mem),
    .rd_mem (bus.rd_mem),
    .wr_wb  (bus.wr_wb),
    .rd_wb  (bus.rd_wb),
    .sel    (fwd_b_raw)
  );

  fwd_unit u_fwd_sd (
    .src    (bus.rs2_id),
    .wr_mem (bus.wr_mem),
    .rd_mem (bus.rd_mem),
    .wr_wb  (bus.wr_wb),
    .rd_wb  (bus.rd_wb),
    .sel    (fwd_sd_raw)
  );

  // While reset is held every decoded control reads as idle, whatever the inputs say
  assign bus.stall_pc    = rst & stall_raw;
  assign bus.stall_ifid  = rst & stall_raw;
  assign bus.flush_ifid  = rst & flush_if_raw;
  assign bus.flush_idex  = rst & flush_id_raw;
  assign bus.freeze      = rst & freeze_raw;
  assign bus.mem_timeout = rst & timeout_raw;
  assign bus.fwd_a       = rst ? fwd_a_raw  : FWD_RF;
  assign bus.fwd_b       = rst ? fwd_b_raw  : FWD_RF;
  assign bus.fwd_sd      = rst ? fwd_sd_raw : FWD_RF;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  // Freeze FSM with watchdog; wait_cnt counts freeze cycles already spent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            state    <= FREEZE;
            wait_cnt <= WAIT_W'(1);
          end
        end
        FREEZE: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (timeout_raw) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_raw && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Saturating count of cycles that inject a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
    end else if ((flush_if_raw || flush_id_raw) && (flush_cnt_q != '1)) begin
      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stall;
  int   exp_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) bus4 ();

  // The short-watchdog instance sees exactly the same stimulus
  assign bus4.rs1_id          = bus.rs1_id;
  assign bus4.rs2_id          = bus.rs2_id;
  assign bus4.rs1_used_id     = bus.rs1_used_id;
  assign bus4.rs2_used_id     = bus.rs2_used_id;
  assign bus4.rd_ex           = bus.rd_ex;
  assign bus4.rd_mem          = bus.rd_mem;
  assign bus4.rd_wb           = bus.rd_wb;
  assign bus4.wr_ex           = bus.wr_ex;
  assign bus4.wr_mem          = bus.wr_mem;
  assign bus4.wr_wb           = bus.wr_wb;
  assign bus4.load_ex         = bus.load_ex;
  assign bus4.branch_taken_ex = bus.branch_taken_ex;
  assign bus4.dmem_req        = bus.dmem_req;
  assign bus4.dmem_ready      = bus.dmem_ready;

  pipe_hazard_ctrl #(.TIMEOUT(64), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.rs1_used_id = 1'b0; bus.rs2_used_id = 1'b0;
    bus.rd_ex = '0; bus.rd_mem = '0; bus.rd_wb = '0;
    bus.wr_ex = 1'b0; bus.wr_mem = 1'b0; bus.wr_wb = 1'b0;
    bus.load_ex = 1'b0; bus.branch_taken_ex = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_in();
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd5;
    bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1; bus.rs2_id = 5'd5;
    bus.wr_mem = 1'b1; bus.rd_mem = 5'd5; bus.wr_wb = 1'b1; bus.rd_wb = 5'd5;
    bus.dmem_req = 1'b1; bus.branch_taken_ex = 1'b1;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL rst_stall_pc got %b want 0", bus.stall_pc); end
    n_cmp++; if (bus.flush_ifid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_ifid got %b want 0", bus.flush_ifid); end
    n_cmp++; if (bus.flush_idex !== 1'b0) begin n_bad++; $display("FAIL rst_flush_idex got %b want 0", bus.flush_idex); end
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL rst_freeze got %b want 0", bus.freeze); end
    n_cmp++; if (bus.fwd_a !== FWD_RF) begin n_bad++; $display("FAIL rst_fwd_a got %b want 00", bus.fwd_a); end
    n_cmp++; if (bus.fwd_sd !== FWD_RF) begin n_bad++; $display("FAIL rst_fwd_sd got %b want 00", bus.fwd_sd); end
    tick();
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_stall_cnt got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus.flush_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_flush_cnt got %0d want 0", bus.flush_cnt); end
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    tick();
    clear_in();
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd5;
    bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b1) begin n_bad++; $display("FAIL lu_stall_pc got %b want 1", bus.stall_pc); end
    n_cmp++; if (bus.stall_ifid !== 1'b1) begin n_bad++; $display("FAIL lu_stall_ifid got %b want 1", bus.stall_ifid); end
    n_cmp++; if (bus.flush_idex !== 1'b1) begin n_bad++; $display("FAIL lu_flush_idex got %b want 1", bus.flush_idex); end
    n_cmp++; if (bus.flush_ifid !== 1'b0) begin n_bad++; $display("FAIL lu_flush_ifid got %b want 0", bus.flush_ifid); end
    tick();
    exp_stall++; exp_flush++;
    // Load has moved to MEM, bubble in EX, dependent still in ID
    clear_in();
    bus.wr_mem = 1'b1; bus.rd_mem = 5'd5; bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL lu_after_stall got %b want 0", bus.stall_pc); end
    n_cmp++; if (bus.fwd_a !== FWD_MEM) begin n_bad++; $display("FAIL lu_after_fwd_a got %b want 10", bus.fwd_a); end
    n_cmp++; if (bus.stall_cnt !== 32'(exp_stall)) begin n_bad++; $display("FAIL lu_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    n_cmp++; if (bus.flush_cnt !== 32'(exp_flush)) begin n_bad++; $display("FAIL lu_flush_cnt got %0d want %0d", bus.flush_cnt, exp_flush); end
    tick();
    // rs2 matches but is not read, then is read
    clear_in();
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd7; bus.rs2_id = 5'd7;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL lu_rs2_unused got %b want 0", bus.stall_pc); end
    bus.rs2_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b1) begin n_bad++; $display("FAIL lu_rs2_used got %b want 1", bus.stall_pc); end
    tick();
    exp_stall++; exp_flush++;
    // A load to x0 never stalls
    clear_in();
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs1_id = 5'd0; bus.rs1_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL lu_x0 got %b want 0", bus.stall_pc); end
    tick();
  endtask

  task automatic test_forward();
    clear_in();
    bus.wr_mem = 1'b1; bus.rd_mem = 5'd3; bus.wr_wb = 1'b1; bus.rd_wb = 5'd3;
    bus.rs2_id = 5'd3; bus.rs2_used_id = 1'b1; bus.rs1_id = 5'd4; bus.rs1_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_b !== FWD_MEM) begin n_bad++; $display("FAIL fwd_b_mem got %b want 10", bus.fwd_b); end
    n_cmp++; if (bus.fwd_sd !== FWD_MEM) begin n_bad++; $display("FAIL fwd_sd_mem got %b want 10", bus.fwd_sd); end
    n_cmp++; if (bus.fwd_a !== FWD_RF) begin n_bad++; $display("FAIL fwd_a_rf got %b want 00", bus.fwd_a); end
    bus.wr_mem = 1'b0;
    #1;
    n_cmp++; if (bus.fwd_b !== FWD_WB) begin n_bad++; $display("FAIL fwd_b_wb got %b want 01", bus.fwd_b); end
    n_cmp++; if (bus.fwd_sd !== FWD_WB) begin n_bad++; $display("FAIL fwd_sd_wb got %b want 01", bus.fwd_sd); end
    bus.rs1_id = 5'd3;
    #1;
    n_cmp++; if (bus.fwd_a !== FWD_WB) begin n_bad++; $display("FAIL fwd_a_wb got %b want 01", bus.fwd_a); end
    // Everything targets x0: no forward, no stall
    bus.wr_mem = 1'b1; bus.rd_mem = 5'd0; bus.rd_wb = 5'd0; bus.rs1_id = 5'd0; bus.rs2_id = 5'd0;
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd0;
    #1;
    n_cmp++; if (bus.fwd_a !== FWD_RF) begin n_bad++; $display("FAIL fwd_x0_a got %b want 00", bus.fwd_a); end
    n_cmp++; if (bus.fwd_b !== FWD_RF) begin n_bad++; $display("FAIL fwd_x0_b got %b want 00", bus.fwd_b); end
    n_cmp++; if (bus.fwd_sd !== FWD_RF) begin n_bad++; $display("FAIL fwd_x0_sd got %b want 00", bus.fwd_sd); end
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL fwd_x0_stall got %b want 0", bus.stall_pc); end
    tick();
  endtask

  task automatic test_branch();
    clear_in();
    bus.branch_taken_ex = 1'b1;
    bus.load_ex = 1'b1; bus.wr_ex = 1'b1; bus.rd_ex = 5'd6; bus.rs1_id = 5'd6; bus.rs1_used_id = 1'b1;
    #1;
    n_cmp++; if (bus.flush_ifid !== 1'b1) begin n_bad++; $display("FAIL br_flush_ifid got %b want 1", bus.flush_ifid); end
    n_cmp++; if (bus.flush_idex !== 1'b1) begin n_bad++; $display("FAIL br_flush_idex got %b want 1", bus.flush_idex); end
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL br_stall_pc got %b want 0", bus.stall_pc); end
    n_cmp++; if (bus.stall_ifid !== 1'b0) begin n_bad++; $display("FAIL br_stall_ifid got %b want 0", bus.stall_ifid); end
    tick();
    exp_flush++;
    clear_in();
    #1;
    n_cmp++; if (bus.flush_cnt !== 32'(exp_flush)) begin n_bad++; $display("FAIL br_flush_cnt got %0d want %0d", bus.flush_cnt, exp_flush); end
    n_cmp++; if (bus.stall_cnt !== 32'(exp_stall)) begin n_bad++; $display("FAIL br_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    n_cmp++; if (bus.flush_ifid !== 1'b0) begin n_bad++; $display("FAIL br_idle_flush got %b want 0", bus.flush_ifid); end
  endtask

  task automatic test_freeze();
    clear_in();
    bus.dmem_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      bus.branch_taken_ex = (c == 3);
      #1;
      n_cmp++; if (bus.freeze !== 1'b1) begin n_bad++; $display("FAIL frz_freeze c%0d got %b want 1", c, bus.freeze); end
      n_cmp++; if (bus.stall_pc !== 1'b1) begin n_bad++; $display("FAIL frz_stall_pc c%0d got %b want 1", c, bus.stall_pc); end
      n_cmp++; if (bus.stall_ifid !== 1'b1) begin n_bad++; $display("FAIL frz_stall_ifid c%0d got %b want 1", c, bus.stall_ifid); end
      n_cmp++; if (bus.flush_ifid !== 1'b0) begin n_bad++; $display("FAIL frz_flush_ifid c%0d got %b want 0", c, bus.flush_ifid); end
      n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL frz_timeout c%0d got %b want 0", c, bus.mem_timeout); end
      tick();
      exp_stall++;
    end
    bus.branch_taken_ex = 1'b0;
    bus.dmem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL frz_ready_freeze got %b want 0", bus.freeze); end
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL frz_ready_stall got %b want 0", bus.stall_pc); end
    tick();
    n_cmp++; if (bus.stall_cnt !== 32'(exp_stall)) begin n_bad++; $display("FAIL frz_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    n_cmp++; if (bus.flush_cnt !== 32'(exp_flush)) begin n_bad++; $display("FAIL frz_flush_cnt got %0d want %0d", bus.flush_cnt, exp_flush); end
    // Back in RUN: a not-ready with no request does not freeze
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    #1;
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL frz_back_run got %b want 0", bus.freeze); end
    tick();
  endtask

  task automatic test_timeout();
    clear_in();
    bus.dmem_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_cmp++; if (bus4.freeze !== 1'b1) begin n_bad++; $display("FAIL to_freeze c%0d got %b want 1", c, bus4.freeze); end
      n_cmp++; if (bus4.mem_timeout !== (c == 4)) begin n_bad++; $display("FAIL to_pulse c%0d got %b want %b", c, bus4.mem_timeout, (c == 4)); end
      n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_long_wd c%0d got %b want 0", c, bus.mem_timeout); end
      tick();
    end
    bus.dmem_req = 1'b0;
    #1;
    n_cmp++; if (bus4.freeze !== 1'b0) begin n_bad++; $display("FAIL to_run got %b want 0", bus4.freeze); end
    n_cmp++; if (bus4.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_end got %b want 0", bus4.mem_timeout); end
    n_cmp++; if (bus.freeze !== 1'b1) begin n_bad++; $display("FAIL to_long_still got %b want 1", bus.freeze); end
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL to_long_release got %b want 0", bus.freeze); end
    tick();
  endtask

  task automatic test_reset_mid_freeze();
    clear_in();
    bus.dmem_req = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (bus.freeze !== 1'b1) begin n_bad++; $display("FAIL rmf_pre got %b want 1", bus.freeze); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL rmf_freeze got %b want 0", bus.freeze); end
    n_cmp++; if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL rmf_stall got %b want 0", bus.stall_pc); end
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rmf_stall_cnt got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus.flush_cnt !== 32'd0) begin n_bad++; $display("FAIL rmf_flush_cnt got %0d want 0", bus.flush_cnt); end
    @(negedge clk);
    rst = 1'b1;
    bus.dmem_req = 1'b0;
    #1;
    n_cmp++; if (bus.freeze !== 1'b0) begin n_bad++; $display("FAIL rmf_run got %b want 0", bus.freeze); end
    n_cmp++; if (bus4.freeze !== 1'b0) begin n_bad++; $display("FAIL rmf_run4 got %b want 0", bus4.freeze); end
    tick();
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rmf_cnt_after got %0d want 0", bus.stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_freeze();
    test_timeout();
    test_reset_mid_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
